// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the parallel CORDIC FFT core: collects a serial sample stream into
// a parallel input bank, starts the core, captures its output and streams the bins back out.
module fft_frame_ctrl #(
  parameter int POINT_FFT_POW2 = 4,
  parameter int POINT_FFT      = 1 << POINT_FFT_POW2,
  parameter int FRAC_BITS      = 15,
  parameter int DATA_WIDTH     = FRAC_BITS + 1,
  parameter int LATENCY        = 48,
  parameter int BITREV_OUT     = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [2*DATA_WIDTH-1:0]           s_data_i,
  output logic                              fft_start_o,
  output logic [POINT_FFT*2*DATA_WIDTH-1:0] fft_data_o,
  input  logic [POINT_FFT*2*DATA_WIDTH-1:0] fft_data_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [2*DATA_WIDTH-1:0]           m_data_o,
  output logic [POINT_FFT_POW2-1:0]         m_index_o,
  output logic                              m_last_o,
  output logic                              busy_o,
  output logic                              frame_done_o
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_e;

  state_e                        state_q, state_d;
  logic [POINT_FFT_POW2-1:0]     wr_cnt_q, wr_cnt_d;
  logic [POINT_FFT_POW2-1:0]     rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]                 lat_cnt_q, lat_cnt_d;
  logic                          in_full_q, in_full_d;
  logic                          frame_done_q, frame_done_d;
  logic [POINT_FFT-1:0][SW-1:0]  in_bank_q, in_bank_d;
  logic [POINT_FFT-1:0][SW-1:0]  out_bank_q, out_bank_d;

  logic                          in_hs;
  logic                          fill_done;
  logic                          last_beat;
  logic [POINT_FFT_POW2-1:0]     rd_idx;

  function automatic logic [POINT_FFT_POW2-1:0] bitrev(input logic [POINT_FFT_POW2-1:0] v);
    logic [POINT_FFT_POW2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < POINT_FFT_POW2; i++) begin
      r[i] = v[POINT_FFT_POW2-1-i];
    end
    return r;
  endfunction

  assign fft_data_o   = in_bank_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != LOAD) || in_full_q || (wr_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    in_full_d    = in_full_q;
    in_bank_d    = in_bank_q;
    out_bank_d   = out_bank_q;
    frame_done_d = 1'b0;

    fft_start_o  = 1'b0;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    m_index_o    = '0;
    m_last_o     = 1'b0;

    s_ready_o = ((state_q == LOAD) || (state_q == UNLOAD)) && !in_full_q;
    in_hs     = s_valid_i && s_ready_o;
    fill_done = in_hs && (wr_cnt_q == POINT_FFT_POW2'(POINT_FFT - 1));
    last_beat = (rd_cnt_q == '1);
    rd_idx    = (BITREV_OUT != 0) ? bitrev(rd_cnt_q) : rd_cnt_q;

    // Loading runs in LOAD and UNLOAD alike, so the next frame fills while this one drains.
    if (in_hs) begin
      in_bank_d[wr_cnt_q] = s_data_i;
      wr_cnt_d            = wr_cnt_q + 1'b1;
    end
    if (fill_done) begin
      in_full_d = 1'b1;
    end

    case (state_q)
      LOAD: begin
        if (in_full_q || fill_done) begin
          state_d = START;
        end
      end
      START: begin
        fft_start_o = 1'b1;
        in_full_d   = 1'b0;
        lat_cnt_d   = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LW'(LATENCY - 1)) begin
          out_bank_d = fft_data_i;
          rd_cnt_d   = '0;
          state_d    = UNLOAD;
        end
      end
      UNLOAD: begin
        m_valid_o = 1'b1;
        m_data_o  = out_bank_q[rd_idx];
        m_index_o = rd_idx;
        m_last_o  = last_beat;
        if (m_ready_i) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (last_beat) begin
            frame_done_d = 1'b1;
            state_d      = (in_full_q || fill_done) ? START : LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= LOAD;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      lat_cnt_q    <= '0;
      in_full_q    <= 1'b0;
      frame_done_q <= 1'b0;
      in_bank_q    <= '0;
      out_bank_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      in_full_q    <= in_full_d;
      frame_done_q <= frame_done_d;
      in_bank_q    <= in_bank_d;
      out_bank_q   <= out_bank_d;
    end
  end

endmodule
